mips_16_core_top: RTL and testbench
===================================

// Module: mips_16_core_top
// PURPOSE
// - 16-bit, 8-register MIPS-style core; 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
// - Top of the CPU: owns instruction ROM, register file, ALU, data RAM, hazard/branch control.
// - Only the fetch PC is exported. Program is preloaded into IF_stage_inst.imem.rom.
// - Benches also read register_file_inst.reg_array[0:7] and the ID-stage word `instruction`.
// PARAMETERS
// - PC_WIDTH   8   word-address width of PC (`PC_WIDTH from mips_16_defs.v)
// - IMEM_DEPTH 256 instruction ROM words (16 bit), rom[0:255]
// - DMEM_DEPTH 256 data RAM words (16 bit)
// PORTS
// - clk  in  1         single clock; all state updates on rising edge
// - rst  in  1         synchronous, active-high reset
// - pc   out PC_WIDTH  address of instruction being fetched (IF stage)
// BEHAVIOUR
// - Encoding: op[15:12], rd[11:9], rs1[8:6], rs2[5:3]; imm6=[5:0] signed; imm9=[8:0] signed.
// - Opcodes:
//   - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
//   - 6 SL: rd=rs1<<rs2[3:0]. 7 SR: arithmetic shift right. 8 SRU: logical shift right.
//   - 9 ADDI: rd=rs1+imm6.
//   - 10 LD: rd=M[rs1+imm6].
//   - 11 ST: M[rs1+imm6]=R[rd].
//   - 12 LI: rd=sext(imm9).
//   - 13 BZ: if R[rd]==0, pc=bpc+1+imm9.
//   - 14 BNZ: if R[rd]!=0, pc=bpc+1+imm9.
//   - 15 J: pc=[11:0] truncated to PC_WIDTH.
// - Arithmetic is 16-bit two's complement, wraps, no flags/exceptions. Address arithmetic wraps mod PC_WIDTH / DMEM size.
// - R0 always reads 0; writes to R0 are discarded.
// - Reset (rst=1 at an edge):
//   - pc=0; all 8 registers = 0; all pipeline registers become NOP (instruction=0).
//   - Data RAM and ROM are untouched.
// - While rst stays high, pc holds at 0. First edge with rst=0: pc 0->1.
// - Normal flow: pc increments by 1 per cycle; wraps 255->0.
// - Register file: written at WB edge. Same-cycle read of the register being written returns the new value (write-through). No other forwarding.
// - RAW hazard, ID vs EX or MEM:
//   - Applies when the ID source register (rs1, rs2, or rd for ST/BZ/BNZ) equals the nonzero destination of a writing instruction in EX or MEM.
//   - Action: hold pc and IF/ID, insert a NOP into ID/EX.
//   - Result: back-to-back dependent ALU ops stall 2 cycles.
// - Branches and J resolve in EX:
//   - If taken: pc loads the target at that edge; IF/ID and ID/EX become NOP (2-cycle penalty).
//   - If not taken: no penalty.
// - Stall and taken branch in the same cycle: branch wins; the stall is dropped.
// - Latency: an independent ALU op fetched at edge N has its result in reg_array after edge N+4.
// - ROM: combinational read. RAM: synchronous write in MEM, combinational read.
// - rst asserted mid-program: every in-flight instruction is squashed. No partial writeback occurs at or after the reset edge.
// TESTING
// 1. Reset: hold rst 1 cycle, then release -> pc=0 during reset, pc=1,2,3... after; R0..R7=0.
// 2. Independent ops:
//    - Program: LI R1,5; LI R2,-3; NOPs.
//    - Result: R1=5, R2=0xFFFD, visible 4 edges after each fetch.
// 3. Hazard:
//    - Program: LI R1,7; ADD R3,R1,R1; SUB R4,R3,R1.
//    - Result: R3=14, R4=7; pc holds for 2 cycles at each dependent instruction.
// 4. Memory:
//    - Program: LI R1,9; ST R1,[R0+4]; LD R5,[R0+4].
//    - Result: R5=9.
// 5. Control flow:
//    - Loop: LI R2,3; ADDI R2,R2,-1; BNZ R2,-2 -> exits with R2=0; the 2 wrong-path instructions do not write.
//    - J 0x10: next pc=16.
// 6. Mid-run reset: assert rst at cycle 20 of a 40-cycle run -> pc=0, registers=0, program restarts cleanly.

Source files
------------

// File: rtl/mips_16_core_top.sv
// 16-bit, 8-register MIPS-style core with a 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
// RAW hazards stall in ID. Branches and jumps resolve in EX and squash IF/ID and ID/EX.

module instruction_mem #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic [AW-1:0] addr,
    output logic [15:0]   data
);
    logic [15:0] rom [0:DEPTH-1];

    assign data = rom[addr];
endmodule

module mips_16_if_stage #(
    parameter int PC_WIDTH   = 8,
    parameter int IMEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instr
);
    // A taken branch overrides a stall in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)               pc <= '0;
        else if (branch_taken) pc <= branch_target;
        else if (!stall)       pc <= pc + PC_WIDTH'(1);
    end

    instruction_mem #(.AW(PC_WIDTH), .DEPTH(IMEM_DEPTH)) imem (.addr(pc), .data(instr));
endmodule

module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    input  logic [2:0]  ra3,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    output logic [15:0] rd3
);
    logic [15:0] reg_array [0:7];

    // Reads of the register being written this cycle see the new value.
    assign rd1 = (ra1 == 3'd0) ? 16'd0 : (we && waddr == ra1) ? wdata : reg_array[ra1];
    assign rd2 = (ra2 == 3'd0) ? 16'd0 : (we && waddr == ra2) ? wdata : reg_array[ra2];
    assign rd3 = (ra3 == 3'd0) ? 16'd0 : (we && waddr == ra3) ? wdata : reg_array[ra3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) reg_array[i] <= 16'd0;
        end else if (we && waddr != 3'd0) begin
            reg_array[waddr] <= wdata;
        end
    end
endmodule

module mips_16_core_top #(
    parameter int PC_WIDTH   = 8,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc
);
    localparam int DA = $clog2(DMEM_DEPTH);
    localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,  OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5,  OP_SL  = 4'd6,  OP_SR  = 4'd7,  OP_SRU = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9, OP_LD  = 4'd10, OP_ST  = 4'd11, OP_LI  = 4'd12;
    localparam logic [3:0] OP_BZ  = 4'd13, OP_BNZ = 4'd14, OP_J   = 4'd15;

    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD && op <= OP_LD) || op == OP_LI;
    endfunction

    logic [15:0]         fetch_word, instruction;
    logic [PC_WIDTH-1:0] id_pc, ex_pc, target;
    logic [15:0]         id_a, id_b, id_d;
    logic [15:0]         ex_instr, ex_a, ex_b, ex_d, ex_res, imm6s, imm9s;
    logic [3:0]          mem_op;
    logic [2:0]          mem_rd, wb_rd;
    logic [15:0]         mem_res, mem_sd, mem_data, wb_data;
    logic                wb_we, stall, taken;
    logic [15:0]         dmem [0:DMEM_DEPTH-1];

    mips_16_if_stage #(.PC_WIDTH(PC_WIDTH), .IMEM_DEPTH(IMEM_DEPTH)) IF_stage_inst (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(taken),
        .branch_target(target), .pc(pc), .instr(fetch_word)
    );

    register_file register_file_inst (
        .clk(clk), .rst(rst), .we(wb_we), .waddr(wb_rd), .wdata(wb_data),
        .ra1(instruction[8:6]), .ra2(instruction[5:3]), .ra3(instruction[11:9]),
        .rd1(id_a), .rd2(id_b), .rd3(id_d)
    );

    // ID: which registers this instruction reads, and whether EX or MEM still owes one of them.
    logic [3:0] id_op, ex_op;
    logic [2:0] ex_rd;
    logic       use_rs1, use_rs2, use_rd, ex_wr, mem_wr, hz_rs1, hz_rs2, hz_rd;

    assign id_op   = instruction[15:12];
    assign ex_op   = ex_instr[15:12];
    assign ex_rd   = ex_instr[11:9];
    assign use_rs1 = id_op >= OP_ADD && id_op <= OP_ST;
    assign use_rs2 = id_op >= OP_ADD && id_op <= OP_SRU;
    assign use_rd  = id_op == OP_ST || id_op == OP_BZ || id_op == OP_BNZ;
    assign ex_wr   = op_writes(ex_op) && ex_rd != 3'd0;
    assign mem_wr  = op_writes(mem_op) && mem_rd != 3'd0;
    assign hz_rs1  = use_rs1 && instruction[8:6] != 3'd0 &&
                     ((ex_wr && instruction[8:6] == ex_rd) || (mem_wr && instruction[8:6] == mem_rd));
    assign hz_rs2  = use_rs2 && instruction[5:3] != 3'd0 &&
                     ((ex_wr && instruction[5:3] == ex_rd) || (mem_wr && instruction[5:3] == mem_rd));
    assign hz_rd   = use_rd && instruction[11:9] != 3'd0 &&
                     ((ex_wr && instruction[11:9] == ex_rd) || (mem_wr && instruction[11:9] == mem_rd));
    assign stall   = hz_rs1 || hz_rs2 || hz_rd;

    always_ff @(posedge clk) begin
        if (rst || taken) begin
            instruction <= 16'd0;
            id_pc       <= '0;
        end else if (!stall) begin
            instruction <= fetch_word;
            id_pc       <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || taken || stall) begin
            ex_instr <= 16'd0;
            ex_pc    <= '0;
            ex_a     <= 16'd0;
            ex_b     <= 16'd0;
            ex_d     <= 16'd0;
        end else begin
            ex_instr <= instruction;
            ex_pc    <= id_pc;
            ex_a     <= id_a;
            ex_b     <= id_b;
            ex_d     <= id_d;
        end
    end

    // EX: ALU result (or memory address) and branch resolution.
    assign imm6s = {{10{ex_instr[5]}}, ex_instr[5:0]};
    assign imm9s = {{7{ex_instr[8]}}, ex_instr[8:0]};

    always_comb begin
        ex_res = 16'd0;
        case (ex_op)
            OP_ADD:                 ex_res = ex_a + ex_b;
            OP_SUB:                 ex_res = ex_a - ex_b;
            OP_AND:                 ex_res = ex_a & ex_b;
            OP_OR:                  ex_res = ex_a | ex_b;
            OP_XOR:                 ex_res = ex_a ^ ex_b;
            OP_SL:                  ex_res = ex_a << ex_b[3:0];
            OP_SR:                  ex_res = 16'($signed(ex_a) >>> ex_b[3:0]);
            OP_SRU:                 ex_res = ex_a >> ex_b[3:0];
            OP_ADDI, OP_LD, OP_ST:  ex_res = ex_a + imm6s;
            OP_LI:                  ex_res = imm9s;
            default:                ex_res = 16'd0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = ex_pc + PC_WIDTH'(1) + imm9s[PC_WIDTH-1:0];
        case (ex_op)
            OP_BZ:   taken = (ex_d == 16'd0);
            OP_BNZ:  taken = (ex_d != 16'd0);
            OP_J: begin
                taken  = 1'b1;
                target = ex_instr[PC_WIDTH-1:0];
            end
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_op  <= 4'd0;
            mem_rd  <= 3'd0;
            mem_res <= 16'd0;
            mem_sd  <= 16'd0;
        end else begin
            mem_op  <= ex_op;
            mem_rd  <= ex_rd;
            mem_res <= ex_res;
            mem_sd  <= ex_d;
        end
    end

    // MEM: data RAM keeps its contents across reset; a store in flight at the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_op == OP_ST) dmem[mem_res[DA-1:0]] <= mem_sd;
    end

    assign mem_data = (mem_op == OP_LD) ? dmem[mem_res[DA-1:0]] : mem_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_rd   <= 3'd0;
            wb_data <= 16'd0;
        end else begin
            wb_we   <= op_writes(mem_op);
            wb_rd   <= mem_rd;
            wb_data <= mem_data;
        end
    end
endmodule

// File: tb/tb_mips_16_core_top.sv
// Bench for mips_16_core_top: an instruction-level model (ISA semantics plus stall/branch timing
// rules) predicts pc and the register file every cycle; literal checks pin key results.

module tb_mips_16_core_top;
    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;

    mips_16_core_top dut (.clk(clk), .rst(rst), .pc(pc));

    // clock / reset
    always #5 clk = ~clk;

    logic [15:0] rom_img [0:255];
    logic [15:0] vis [0:MAXC][0:7];
    logic [7:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          checking = 1'b0;

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) rom_img[i] = 16'h0000;
    endtask

    task automatic commit_prog();
        for (int i = 0; i < 256; i++) dut.IF_stage_inst.imem.rom[i] = rom_img[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pc", 0, 16'(pc), 16'h0000);
        check("rst_instr", 0, dut.instruction, 16'h0000);
        for (int i = 0; i < 8; i++) check("rst_reg", i, dut.register_file_inst.reg_array[i], 16'h0000);
        rst = 1'b0;
    endtask

    // Model: walk the correct path in program order; each instruction leaves ID once every
    // source produced by an earlier instruction is in WB; taken branches cost two bubbles.
    task automatic build_model(input int ncyc);
        logic [15:0] r [0:7];
        logic [15:0] m [0:255];
        int          avail [0:7];
        int          pcv [0:MAXC+3];
        int          a, d, s, x, w, tgt, imm6, imm9, addr;
        logic [15:0] ins, va, vb, vd, val;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        bit          wr, tk;
        for (int i = 0; i < 8; i++) begin r[i] = 16'd0; avail[i] = 0; end
        for (int i = 0; i < 256; i++) m[i] = 16'd0;
        for (int c = 0; c <= MAXC; c++) for (int i = 0; i < 8; i++) vis[c][i] = 16'd0;
        for (int c = 0; c <= MAXC + 3; c++) pcv[c] = 0;
        a = 0;
        d = 1;
        while (d < ncyc) begin
            ins  = rom_img[a];
            op   = ins[15:12];
            rd   = ins[11:9];
            rs1  = ins[8:6];
            rs2  = ins[5:3];
            imm6 = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            imm9 = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
            s = d;
            if (op >= 1 && op <= 11 && rs1 != 0 && avail[rs1] > s) s = avail[rs1];
            if (op >= 1 && op <= 8 && rs2 != 0 && avail[rs2] > s) s = avail[rs2];
            if ((op == 11 || op == 13 || op == 14) && rd != 0 && avail[rd] > s) s = avail[rd];
            for (int c = d; c <= s; c++) if (c <= MAXC + 3) pcv[c] = (a + 1) % 256;
            x  = s + 1;
            va = r[rs1];
            vb = r[rs2];
            vd = r[rd];
            wr = (op >= 1 && op <= 10) || op == 12;
            tk = 1'b0;
            tgt = 0;
            val = 16'd0;
            addr = (int'(va) + imm6) & 255;
            case (op)
                1:  val = va + vb;
                2:  val = va - vb;
                3:  val = va & vb;
                4:  val = va | vb;
                5:  val = va ^ vb;
                6:  val = va << vb[3:0];
                7:  val = 16'($signed(va) >>> vb[3:0]);
                8:  val = va >> vb[3:0];
                9:  val = 16'(int'(va) + imm6);
                10: val = m[addr];
                11: m[addr] = vd;
                12: val = 16'(imm9);
                13: begin tk = (vd == 16'd0); tgt = (a + 1 + imm9) & 255; end
                14: begin tk = (vd != 16'd0); tgt = (a + 1 + imm9) & 255; end
                15: begin tk = 1'b1; tgt = int'(ins[7:0]); end
                default: val = 16'd0;
            endcase
            if (wr && rd != 0) begin
                r[rd] = val;
                w = x + 2;
                avail[rd] = w;
                for (int c = w + 1; c <= MAXC; c++) vis[c][rd] = val;
            end
            if (tk) begin
                if (x <= MAXC + 3) pcv[x] = (a + 2) % 256;
                if (x + 1 <= MAXC + 3) pcv[x + 1] = tgt;
                d = x + 2;
                a = tgt;
            end else begin
                a = (a + 1) % 256;
                d = x;
            end
        end
        exp_q.delete();
        for (int c = 0; c < ncyc; c++) exp_q.push_back(8'(pcv[c]));
    endtask

    task automatic run_prog(input int ncyc);
        commit_prog();
        do_reset();
        build_model(ncyc);
        cyc = 0;
        checking = 1'b1;
        repeat (ncyc) @(posedge clk);
        checking = 1'b0;
        #1;
    endtask

    // scoreboard: compare pc and all registers with the model on every cycle after reset release
    always @(negedge clk) begin
        if (checking) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pc_queue at %0t: got %h expected <none>", $time, pc);
            end else begin
                check("pc", cyc, 16'(pc), 16'(exp_q.pop_front()));
            end
            for (int i = 0; i < 8; i++) check("reg", i, dut.register_file_inst.reg_array[i], vis[cyc][i]);
            cyc++;
        end
    end

    initial begin
        rst = 1'b1;
        clear_prog();
        commit_prog();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_pc", 0, 16'(pc), 16'h0000);
        end

        // independent LIs
        clear_prog();
        rom_img[0] = 16'hC205;
        rom_img[1] = 16'hC5FD;
        run_prog(4);
        check("lat_r1_early", 1, dut.register_file_inst.reg_array[1], 16'h0000);
        run_prog(5);
        check("lat_r1", 1, dut.register_file_inst.reg_array[1], 16'h0005);
        run_prog(16);
        check("li_r1", 1, dut.register_file_inst.reg_array[1], 16'h0005);
        check("li_r2", 2, dut.register_file_inst.reg_array[2], 16'hFFFD);
        check("free_pc", 0, 16'(pc), 16'd16);

        // RAW hazards
        clear_prog();
        rom_img[0] = 16'hC207;
        rom_img[1] = 16'h1648;
        rom_img[2] = 16'h28C8;
        run_prog(4);
        check("stall_pc", 0, 16'(pc), 16'd2);
        check("stall_instr", 0, dut.instruction, 16'h1648);
        run_prog(16);
        check("hz_r3", 3, dut.register_file_inst.reg_array[3], 16'd14);
        check("hz_r4", 4, dut.register_file_inst.reg_array[4], 16'd7);

        // store / load
        clear_prog();
        rom_img[0] = 16'hC209;
        rom_img[1] = 16'hB204;
        rom_img[2] = 16'hAA04;
        run_prog(16);
        check("ld_r5", 5, dut.register_file_inst.reg_array[5], 16'd9);

        // ALU ops, R0 write, BZ not-taken and taken
        clear_prog();
        rom_img[0]  = 16'hC3F8;
        rom_img[1]  = 16'hC402;
        rom_img[2]  = 16'hC6F3;
        rom_img[3]  = 16'h6850;
        rom_img[4]  = 16'h7A50;
        rom_img[5]  = 16'h8C50;
        rom_img[6]  = 16'h5E58;
        rom_img[7]  = 16'h4050;
        rom_img[8]  = 16'h34C8;
        rom_img[9]  = 16'hD205;
        rom_img[10] = 16'hD002;
        rom_img[11] = 16'hC611;
        rom_img[12] = 16'hC611;
        rom_img[13] = 16'hC222;
        run_prog(50);
        check("sl_r4", 4, dut.register_file_inst.reg_array[4], 16'hFFE0);
        check("sr_r5", 5, dut.register_file_inst.reg_array[5], 16'hFFFE);
        check("sru_r6", 6, dut.register_file_inst.reg_array[6], 16'h3FFE);
        check("xor_r7", 7, dut.register_file_inst.reg_array[7], 16'hFF0B);
        check("and_r2", 2, dut.register_file_inst.reg_array[2], 16'h00F0);
        check("bz_skip_r3", 3, dut.register_file_inst.reg_array[3], 16'h00F3);
        check("bz_tgt_r1", 1, dut.register_file_inst.reg_array[1], 16'h0022);
        check("r0_zero", 0, dut.register_file_inst.reg_array[0], 16'h0000);

        // jump alone
        clear_prog();
        rom_img[0] = 16'hF010;
        run_prog(3);
        check("j_pc", 0, 16'(pc), 16'd16);

        // counted loop, wrong-path guard, jump; then mid-run reset and clean restart
        clear_prog();
        rom_img[0]  = 16'hC403;
        rom_img[1]  = 16'h94BF;
        rom_img[2]  = 16'hE5FE;
        rom_img[3]  = 16'h9D81;
        rom_img[4]  = 16'h9D81;
        rom_img[5]  = 16'hF010;
        rom_img[16] = 16'hCE55;
        run_prog(20);
        run_prog(40);
        check("loop_r2", 2, dut.register_file_inst.reg_array[2], 16'h0000);
        check("loop_r6", 6, dut.register_file_inst.reg_array[6], 16'h0002);
        check("loop_r7", 7, dut.register_file_inst.reg_array[7], 16'h0055);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
